// File: rtl/fetch_pc_gen_pkg.sv
// rtl/fetch_pc_gen_pkg.sv - shared BTB counter and fetch FSM definitions
//
// Purpose: counter width, allocate value, FSM state encoding and the
// counter update helper shared by the fetch PC generator and its BTB bank.
// Config macro: FETCH_BTB_2BIT_EN selects a 2-bit saturating counter per
// entry; when undefined each entry keeps a 1-bit last-outcome bit.
package fetch_pc_gen_pkg;

`ifdef FETCH_BTB_2BIT_EN
    localparam int BTB_CTR_W = 2;
    // New entries start weakly taken.
    localparam logic [BTB_CTR_W-1:0] BTB_CTR_WT = 2'b10;
`else
    localparam int BTB_CTR_W = 1;
    localparam logic [BTB_CTR_W-1:0] BTB_CTR_WT = 1'b1;
`endif

    typedef enum logic {
        FPC_INIT = 1'b0,
        FPC_RUN  = 1'b1
    } fpc_state_e;

    // Saturating step toward the resolved direction. With a 1-bit counter
    // this degenerates to "store the outcome".
    function automatic logic [BTB_CTR_W-1:0] ctr_next(
        input logic [BTB_CTR_W-1:0] ctr,
        input logic                 taken
    );
        logic [BTB_CTR_W-1:0] one;
        one = {{(BTB_CTR_W-1){1'b0}}, 1'b1};
        if (taken) begin
            ctr_next = (&ctr) ? ctr : ctr + one;
        end else begin
            ctr_next = (ctr == '0) ? ctr : ctr - one;
        end
    endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// rtl/fetch_pc_gen_if.sv - execute-to-fetch redirect and BTB training bus
//
// Signals:
//   redirect     execute mispredict; load redirect_pc into the fetch PC
//   redirect_pc  corrected fetch PC
//   upd_valid    a branch/jump resolved in execute this cycle
//   upd_pc       PC of the resolved instruction
//   upd_taken    actual direction
//   upd_tgt      actual target
// Modports: master = execute side (drives), slave = fetch side (samples).
interface fetch_pc_gen_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_tgt;

    modport master (
        output redirect, redirect_pc, upd_valid, upd_pc, upd_taken, upd_tgt
    );

    modport slave (
        input  redirect, redirect_pc, upd_valid, upd_pc, upd_taken, upd_tgt
    );
endinterface

// File: rtl/fetch_pc_gen_btb_bank.sv
// rtl/fetch_pc_gen_btb_bank.sv - direct-mapped BTB entry array
//
// Purpose: holds valid/tag/target/counter per entry.
// Ports:
//   clock_i                 core clock
//   rd_idx_0/1, rd_*_0/1    async read ports for fetch slots 0 and 1
//   rd_idx_u, rd_*_u        async read of the entry being trained
//   wr_en, wr_idx, wr_tag,
//   wr_ctr, wr_tgt_en,
//   wr_tgt                  sync write; sets valid, target written only
//                           when wr_tgt_en
//   clr_en, clr_idx         sync clear of valid/ctr, driven by the sweep
// No reset on the array: the init sweep clears every entry.
module fetch_pc_gen_btb_bank #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clock_i,

    input  logic [IDX_W-1:0] rd_idx_0,
    output logic             rd_valid_0,
    output logic [TAG_W-1:0] rd_tag_0,
    output logic [31:0]      rd_tgt_0,
    output logic [CTR_W-1:0] rd_ctr_0,

    input  logic [IDX_W-1:0] rd_idx_1,
    output logic             rd_valid_1,
    output logic [TAG_W-1:0] rd_tag_1,
    output logic [31:0]      rd_tgt_1,
    output logic [CTR_W-1:0] rd_ctr_1,

    input  logic [IDX_W-1:0] rd_idx_u,
    output logic             rd_valid_u,
    output logic [TAG_W-1:0] rd_tag_u,
    output logic [CTR_W-1:0] rd_ctr_u,

    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [CTR_W-1:0] wr_ctr,
    input  logic             wr_tgt_en,
    input  logic [31:0]      wr_tgt,

    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic [CTR_W-1:0] ctr_q   [ENTRIES];

    always_ff @(posedge clock_i) begin
        if (clr_en) begin
            valid_q[clr_idx] <= 1'b0;
            ctr_q[clr_idx]   <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            ctr_q[wr_idx]   <= wr_ctr;
            if (wr_tgt_en) begin
                tgt_q[wr_idx] <= wr_tgt;
            end
        end
    end

    // Reads see the pre-write contents: no same-cycle bypass.
    assign rd_valid_0 = valid_q[rd_idx_0];
    assign rd_tag_0   = tag_q[rd_idx_0];
    assign rd_tgt_0   = tgt_q[rd_idx_0];
    assign rd_ctr_0   = ctr_q[rd_idx_0];

    assign rd_valid_1 = valid_q[rd_idx_1];
    assign rd_tag_1   = tag_q[rd_idx_1];
    assign rd_tgt_1   = tgt_q[rd_idx_1];
    assign rd_ctr_1   = ctr_q[rd_idx_1];

    assign rd_valid_u = valid_q[rd_idx_u];
    assign rd_tag_u   = tag_q[rd_idx_u];
    assign rd_ctr_u   = ctr_q[rd_idx_u];

endmodule

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - F1 fetch PC generator with dual-slot BTB lookup
//
// Purpose: holds the fetch PC, predicts both fetch slots (pc, pc+4) from a
// direct-mapped BTB, trains the BTB from execute, and stalls F1 while the
// BTB is swept clear after reset.
// Ports:
//   clock_i, reset_i        clock, synchronous active-high reset
//   frontend_we_i           advance the PC when high
//   ex_if (slave)           redirect / redirect_pc and upd_* training bus
//   pc_o                    slot-0 fetch PC (slot 1 = pc_o+4)
//   pred_0_o, pred_tgt_0_o  slot-0 predicted taken / target
//   pred_1_o, pred_tgt_1_o  slot-1 predicted taken / target
//   stall_o                 high during the init sweep
// Config macro: FETCH_BTB_2BIT_EN (2-bit counters; 1-bit outcome bit
// otherwise), consumed through fetch_pc_gen_pkg.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int          BTB_ENTRIES = 16,
    parameter int          TAG_W       = 8,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          frontend_we_i,
    fetch_pc_gen_if.slave ex_if,
    output logic [31:0]   pc_o,
    output logic          pred_0_o,
    output logic          pred_1_o,
    output logic [31:0]   pred_tgt_0_o,
    output logic [31:0]   pred_tgt_1_o,
    output logic          stall_o
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    // Lookup key = index bits followed by tag bits, starting at pc[2].
    localparam int KEY_W = IDX_W + TAG_W;
    localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(BTB_ENTRIES - 1);
    localparam logic [IDX_W-1:0] SWEEP_ONE  = IDX_W'(1);
    localparam logic [KEY_W-1:0] KEY_ONE    = KEY_W'(1);

    fpc_state_e       state_q, state_d;
    logic [IDX_W-1:0] sweep_q;
    logic             run;
    logic [31:0]      pc_q;
    logic [31:0]      pc_next;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= FPC_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FPC_INIT) begin
                sweep_q <= sweep_q + SWEEP_ONE;
            end
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (state_q == FPC_INIT && sweep_q == SWEEP_LAST) begin
            state_d = FPC_RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        stall_o = 1'b0;
        run     = 1'b0;
        if (state_q == FPC_INIT) begin
            stall_o = 1'b1;
        end else begin
            run = 1'b1;
        end
    end

    // ---------------- Lookup ----------------
    logic [KEY_W-1:0]     key_0, key_1, key_u;
    logic                 rd_valid_0, rd_valid_1, rd_valid_u;
    logic [TAG_W-1:0]     rd_tag_0, rd_tag_1, rd_tag_u;
    logic [31:0]          rd_tgt_0, rd_tgt_1;
    logic [BTB_CTR_W-1:0] rd_ctr_0, rd_ctr_1, rd_ctr_u;
    logic                 hit_0, hit_1, hit_u;

    assign key_0 = pc_q[2 +: KEY_W];
    // Slot 1 is pc+4; only the key bits of that sum matter.
    assign key_1 = key_0 + KEY_ONE;
    assign key_u = ex_if.upd_pc[2 +: KEY_W];

    logic unused_upd_pc_bits;
    assign unused_upd_pc_bits = ^{ex_if.upd_pc[31:KEY_W+2], ex_if.upd_pc[1:0]};

    assign hit_0 = run && rd_valid_0 && (rd_tag_0 == key_0[KEY_W-1:IDX_W]);
    assign hit_1 = run && rd_valid_1 && (rd_tag_1 == key_1[KEY_W-1:IDX_W]);
    assign hit_u = rd_valid_u && (rd_tag_u == key_u[KEY_W-1:IDX_W]);

    assign pred_0_o     = hit_0 && rd_ctr_0[BTB_CTR_W-1];
    assign pred_1_o     = hit_1 && rd_ctr_1[BTB_CTR_W-1];
    assign pred_tgt_0_o = hit_0 ? rd_tgt_0 : 32'h0;
    assign pred_tgt_1_o = hit_1 ? rd_tgt_1 : 32'h0;

    // ---------------- Training ----------------
    logic                 wr_en, wr_tgt_en;
    logic [BTB_CTR_W-1:0] wr_ctr;

    always_comb begin
        wr_en     = 1'b0;
        wr_tgt_en = 1'b0;
        wr_ctr    = BTB_CTR_WT;
        if (run && ex_if.upd_valid) begin
            if (hit_u) begin
                wr_en     = 1'b1;
                wr_ctr    = ctr_next(rd_ctr_u, ex_if.upd_taken);
                wr_tgt_en = ex_if.upd_taken;
            end else if (ex_if.upd_taken) begin
                wr_en     = 1'b1;
                wr_tgt_en = 1'b1;
                wr_ctr    = BTB_CTR_WT;
            end
        end
    end

    fetch_pc_gen_btb_bank #(
        .ENTRIES (BTB_ENTRIES),
        .TAG_W   (TAG_W),
        .CTR_W   (BTB_CTR_W)
    ) u_bank (
        .clock_i    (clock_i),
        .rd_idx_0   (key_0[IDX_W-1:0]),
        .rd_valid_0 (rd_valid_0),
        .rd_tag_0   (rd_tag_0),
        .rd_tgt_0   (rd_tgt_0),
        .rd_ctr_0   (rd_ctr_0),
        .rd_idx_1   (key_1[IDX_W-1:0]),
        .rd_valid_1 (rd_valid_1),
        .rd_tag_1   (rd_tag_1),
        .rd_tgt_1   (rd_tgt_1),
        .rd_ctr_1   (rd_ctr_1),
        .rd_idx_u   (key_u[IDX_W-1:0]),
        .rd_valid_u (rd_valid_u),
        .rd_tag_u   (rd_tag_u),
        .rd_ctr_u   (rd_ctr_u),
        .wr_en      (wr_en),
        .wr_idx     (key_u[IDX_W-1:0]),
        .wr_tag     (key_u[KEY_W-1:IDX_W]),
        .wr_ctr     (wr_ctr),
        .wr_tgt_en  (wr_tgt_en),
        .wr_tgt     (ex_if.upd_tgt),
        .clr_en     (stall_o),
        .clr_idx    (sweep_q)
    );

    // ---------------- Next PC ----------------
    // Slot 0 wins over slot 1: a taken slot 0 means slot 1 never executes.
    always_comb begin
        if (pred_0_o) begin
            pc_next = rd_tgt_0;
        end else if (pred_1_o) begin
            pc_next = rd_tgt_1;
        end else begin
            pc_next = pc_q + 32'd8;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else if (run) begin
            if (ex_if.redirect) begin
                pc_q <= ex_if.redirect_pc;
            end else if (frontend_we_i) begin
                pc_q <= pc_next;
            end
        end
    end

    assign pc_o = pc_q;

endmodule
